led_pattern_gen: RTL

//  Parametrised LED pattern generator; successor to the fixed-step LED counter.

---
 rtl/led_pattern_gen_pkg.sv | 18 +
 rtl/led_tick_gen.sv | 40 ++++
 rtl/led_pattern_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings and bounce direction.
package led_pattern_gen_pkg;

  localparam int unsigned MODE_WIDTH = 2;

  typedef enum logic [MODE_WIDTH-1:0] {
    LED_MODE_UP     = 2'd0,
    LED_MODE_DOWN   = 2'd1,
    LED_MODE_ROTATE = 2'd2,
    LED_MODE_BOUNCE = 2'd3
  } led_mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: holds the run-time step register and the cycle counter, flags the tick cycle.
module led_tick_gen #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned STEP      = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic [CNT_WIDTH-1:0] STEP_IN,
  input  logic                 STEP_LOAD,
  input  logic                 clear,
  output logic                 tick_en
);

  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] step;

  // Tick when the counter reaches the last cycle of the period while running.
  assign tick_en = ENABLE && (count == (step - CNT_WIDTH'(1)));

  // Step load beats clear beats counting; a zero step is promoted to one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      step  <= CNT_WIDTH'(STEP);
    end else if (STEP_LOAD) begin
      step  <= (STEP_IN == '0) ? CNT_WIDTH'(1) : STEP_IN;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (ENABLE) begin
      if (tick_en) begin
        count <= '0;
      end else begin
        count <= count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled up/down/rotate/bounce patterns on a WIDTH-bit LED register.
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned STEP      = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic [MODE_WIDTH-1:0] MODE,
  input  logic [CNT_WIDTH-1:0]  STEP_IN,
  input  logic                  STEP_LOAD,
  output logic [WIDTH-1:0]      LED,
  output logic                  TICK,
  output logic                  WRAP
);

  led_mode_e        mode_q;
  led_mode_e        mode_in;
  dir_e             dir;
  logic             mode_change;
  logic             tick_en;

  logic [WIDTH-1:0] led_init;
  logic [WIDTH-1:0] led_step;
  logic [WIDTH-1:0] led_shift;
  dir_e             dir_step;
  logic             wrap_step;

  logic [WIDTH-1:0] led_d;
  dir_e             dir_d;
  led_mode_e        mode_d;
  logic             tick_d;
  logic             wrap_d;

  assign mode_in     = led_mode_e'(MODE);
  assign mode_change = (mode_in != mode_q);

  led_tick_gen #(
    .CNT_WIDTH (CNT_WIDTH),
    .STEP      (STEP)
  ) u_tick_gen (
    .CLK       (CLK),
    .RST       (RST),
    .ENABLE    (ENABLE),
    .STEP_IN   (STEP_IN),
    .STEP_LOAD (STEP_LOAD),
    .clear     (mode_change),
    .tick_en   (tick_en)
  );

  // Starting pattern applied when a new mode is selected.
  always_comb begin
    led_init = '0;
    case (mode_in)
      LED_MODE_UP:     led_init = '0;
      LED_MODE_DOWN:   led_init = '1;
      LED_MODE_ROTATE: led_init = WIDTH'(1);
      LED_MODE_BOUNCE: led_init = WIDTH'(1);
      default:         led_init = '0;
    endcase
  end

  // Next pattern on a tick for the active mode, with its wrap/reversal flag.
  always_comb begin
    led_step  = LED;
    dir_step  = dir;
    wrap_step = 1'b0;
    led_shift = (dir == DIR_LEFT) ? (LED << 1) : (LED >> 1);
    case (mode_q)
      LED_MODE_UP: begin
        led_step  = LED + WIDTH'(1);
        wrap_step = &LED;
      end
      LED_MODE_DOWN: begin
        led_step  = LED - WIDTH'(1);
        wrap_step = ~|LED;
      end
      LED_MODE_ROTATE: begin
        if (~|LED) begin
          led_step = WIDTH'(1);
        end else begin
          led_step  = {LED[WIDTH-2:0], LED[WIDTH-1]};
          wrap_step = LED[WIDTH-1];
        end
      end
      LED_MODE_BOUNCE: begin
        if (~|LED) begin
          led_step = WIDTH'(1);
        end else begin
          led_step = led_shift;
          if (led_shift[WIDTH-1]) begin
            dir_step  = DIR_RIGHT;
            wrap_step = 1'b1;
          end else if (led_shift[0]) begin
            dir_step  = DIR_LEFT;
            wrap_step = 1'b1;
          end
        end
      end
      default: begin
        led_step = LED;
      end
    endcase
  end

  // Edge priority: step load holds everything, then mode change, then tick.
  always_comb begin
    led_d  = LED;
    dir_d  = dir;
    mode_d = mode_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (!STEP_LOAD) begin
      if (mode_change) begin
        mode_d = mode_in;
        dir_d  = DIR_LEFT;
        led_d  = led_init;
      end else if (tick_en) begin
        led_d  = led_step;
        dir_d  = dir_step;
        tick_d = 1'b1;
        wrap_d = wrap_step;
      end
    end
  end

  // Pattern state and output pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q <= LED_MODE_UP;
      dir    <= DIR_LEFT;
      LED    <= '0;
      TICK   <= 1'b0;
      WRAP   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir    <= dir_d;
      LED    <= led_d;
      TICK   <= tick_d;
      WRAP   <= wrap_d;
    end
  end

endmodule
